// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   RS / RD          : register-index widths of source / destination fields.
//   *_DEF            : default values of the controller parameters.
//   state_e          : controller FSM encoding (also exported on state_o).
package pipeline_ctrl_pkg;

  localparam int RS = 5;
  localparam int RD = 5;

  localparam int MEM_TIMEOUT_DEF  = 15;
  localparam int FLUSH_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags a hazard when an Issue-slot load writes a
// non-zero register that either Decode slot reads.
//   rs1_i, rs2_i : source registers of Decode slots 0/1
//   rd_i         : destination registers of Issue slots 0/1
//   load_i       : load flag per Issue slot
//   hazard_o     : any load-use dependency present
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [1:0][RS-1:0] rs1_i,
  input  logic [1:0][RS-1:0] rs2_i,
  input  logic [1:0][RD-1:0] rd_i,
  input  logic [1:0]         load_i,
  output logic               hazard_o
);

  // NOTE: assign a default before the loops so every path drives hazard_o
  // and no latch is inferred.
  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        // x0 is hard-wired zero, so a load targeting it creates no dependency.
        if (load_i[i] && (rd_i[i] != '0) &&
            ((rd_i[i] == rs1_i[j]) || (rd_i[i] == rs2_i[j]))) begin
          hazard_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for a dual-issue pipeline.
//   clk, rst                     : clock, synchronous active-high reset
//   rs1_De, rs2_De, rd_Issue,
//   mem_read_en_Issue            : load-use operands
//   branch_taken_Ex              : taken-branch redirect from Execute
//   mem_req_Mem, mem_ready_Mem   : data-memory handshake in Mem
//   stall_*                      : hold PC / stage register
//   flush_*                      : bubble the stage register
//   mem_timeout                  : sticky memory-wait timeout flag
//   state_o                      : current FSM state (debug)
// Priority: memory wait > branch flush > load-use.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0][RS-1:0] rs1_De,
  input  logic [1:0][RS-1:0] rs2_De,
  input  logic [1:0][RD-1:0] rd_Issue,
  input  logic [1:0]         mem_read_en_Issue,
  input  logic               branch_taken_Ex,
  input  logic               mem_req_Mem,
  input  logic               mem_ready_Mem,
  output logic               stall_F,
  output logic               stall_De,
  output logic               stall_Issue,
  output logic               stall_Ex,
  output logic               stall_Mem,
  output logic               flush_De,
  output logic               flush_Issue,
  output logic               flush_WB,
  output logic               mem_timeout,
  output logic [1:0]         state_o
);

  localparam int         WCW          = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MEM_TIMEOUT);
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]     flush_cnt_q, flush_cnt_d;
  logic           pending_q, pending_d;
  logic           timeout_q, timeout_d;

  logic load_use;
  logic stall_all, stall_lu, flush_de, flush_is, take_branch;

  hazard_detect u_hazard_detect (
    .rs1_i    (rs1_De),
    .rs2_i    (rs2_De),
    .rd_i     (rd_Issue),
    .load_i   (mem_read_en_Issue),
    .hazard_o (load_use)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pending_d   = pending_q;
    timeout_d   = timeout_q;
    stall_all   = 1'b0;
    stall_lu    = 1'b0;
    flush_de    = 1'b0;
    flush_is    = 1'b0;
    take_branch = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_req_Mem && !mem_ready_Mem) begin
          stall_all  = 1'b1;
          wait_cnt_d = '0;
          // A branch resolving alongside the memory stall is remembered
          // rather than dropped.
          pending_d  = branch_taken_Ex;
          state_d    = ST_MEM_WAIT;
        end else if (branch_taken_Ex) begin
          take_branch = 1'b1;
        end else if (load_use) begin
          stall_lu = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (mem_ready_Mem || (wait_cnt_q == WAIT_LIMIT)) begin
          if (wait_cnt_q == WAIT_LIMIT) timeout_d = 1'b1;
          pending_d = 1'b0;
          if (pending_q || branch_taken_Ex) take_branch = 1'b1;
          else                              state_d     = ST_RUN;
        end else begin
          stall_all  = 1'b1;
          pending_d  = pending_q | branch_taken_Ex;
          // Exit fires at WAIT_LIMIT, so this increment never wraps.
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_FLUSH: begin
        flush_de = 1'b1;
        if (branch_taken_Ex) begin
          take_branch = 1'b1;
        end else if (flush_cnt_q <= 2'd1) begin
          flush_cnt_d = '0;
          state_d     = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end

      default: state_d = ST_RUN;
    endcase

    // Shared redirect action: bubble Decode and Issue now, keep Decode
    // flushed for the remaining FLUSH_CYCLES-1 cycles.
    if (take_branch) begin
      flush_de    = 1'b1;
      flush_is    = 1'b1;
      flush_cnt_d = FLUSH_RELOAD;
      state_d     = (FLUSH_RELOAD != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      pending_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pending_q   <= pending_d;
      timeout_q   <= timeout_d;
    end
  end

  // Outputs are forced low while reset is held so the pipeline sees no
  // stall or flush from stale state.
  assign stall_F     = !rst && (stall_all || stall_lu);
  assign stall_De    = !rst && (stall_all || stall_lu);
  assign stall_Issue = !rst && stall_all;
  assign stall_Ex    = !rst && stall_all;
  assign stall_Mem   = !rst && stall_all;
  assign flush_De    = !rst && flush_de;
  assign flush_Issue = !rst && (flush_is || stall_lu);
  assign flush_WB    = !rst && stall_all;
  assign mem_timeout = !rst && timeout_q;
  assign state_o     = rst ? 2'd0 : state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: expected output
// vectors are queued as each cycle's stimulus is applied and compared at
// the following falling edge.
module tb_pipeline_hazard_controller;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][4:0]  rs1_De, rs2_De, rd_Issue;
  logic [1:0]       mem_read_en_Issue;
  logic             branch_taken_Ex, mem_req_Mem, mem_ready_Mem;
  logic             stall_F, stall_De, stall_Issue, stall_Ex, stall_Mem;
  logic             flush_De, flush_Issue, flush_WB, mem_timeout;
  logic [1:0]       state_o;

  int n_checks = 0;
  int n_errors = 0;

  // Expected-vector fields {stalls F,De,Issue,Ex,Mem}, {flush De,Issue,WB}
  localparam logic [4:0] ST_NONE = 5'b00000;
  localparam logic [4:0] ST_ALL  = 5'b11111;
  localparam logic [4:0] ST_LU   = 5'b11000;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_LU   = 3'b010;
  localparam logic [2:0] FL_WB   = 3'b001;
  localparam logic [2:0] FL_BR   = 3'b110;
  localparam logic [2:0] FL_DE   = 3'b100;
  localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd1, S_FL = 2'd2;

  typedef struct { string tag; logic [10:0] v; } exp_t;
  exp_t sb_q[$];

  pipeline_hazard_controller #(.MEM_TIMEOUT(15), .FLUSH_CYCLES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .rs1_De            (rs1_De),
    .rs2_De            (rs2_De),
    .rd_Issue          (rd_Issue),
    .mem_read_en_Issue (mem_read_en_Issue),
    .branch_taken_Ex   (branch_taken_Ex),
    .mem_req_Mem       (mem_req_Mem),
    .mem_ready_Mem     (mem_ready_Mem),
    .stall_F           (stall_F),
    .stall_De          (stall_De),
    .stall_Issue       (stall_Issue),
    .stall_Ex          (stall_Ex),
    .stall_Mem         (stall_Mem),
    .flush_De          (flush_De),
    .flush_Issue       (flush_Issue),
    .flush_WB          (flush_WB),
    .mem_timeout       (mem_timeout),
    .state_o           (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] ev(input logic [4:0] st, input logic [2:0] fl,
                                     input logic to, input logic [1:0] s);
    return {st, fl, to, s};
  endfunction

  // Reference load-use rule: does any Decode source get written by a
  // non-x0 load in Issue?
  function automatic logic ref_hazard(input logic [1:0][4:0] r1, r2, rd,
                                      input logic [1:0] ld);
    logic [3:0][4:0] srcs;
    logic hz;
    srcs = {r1[0], r1[1], r2[0], r2[1]};
    hz = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((ld[0] && rd[0] == srcs[k] && rd[0] != 5'd0) ||
          (ld[1] && rd[1] == srcs[k] && rd[1] != 5'd0)) hz = 1'b1;
    end
    return hz;
  endfunction

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (stall5 flush3 timeout state2)", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1_De = '0; rs2_De = '0; rd_Issue = '0; mem_read_en_Issue = '0;
    branch_taken_Ex = 1'b0; mem_req_Mem = 1'b0; mem_ready_Mem = 1'b0;
  endtask

  task automatic set_load_use();
    rd_Issue[0] = 5'd5; mem_read_en_Issue[0] = 1'b1; rs2_De[1] = 5'd5;
  endtask

  // Queue the expectation for the inputs just applied, compare at the
  // falling edge, then move to just after the next rising edge.
  task automatic step(input string tag, input logic [10:0] v);
    exp_t x;
    x.tag = tag; x.v = v;
    sb_q.push_back(x);
    @(negedge clk);
    x = sb_q.pop_front();
    check(x.tag, {stall_F, stall_De, stall_Issue, stall_Ex, stall_Mem,
                  flush_De, flush_Issue, flush_WB, mem_timeout, state_o}, x.v);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] zero;
    zero = ev(ST_NONE, FL_NONE, 1'b0, S_RUN);
    rst = 1'b1;
    idle();
    @(posedge clk); #1;

    // Reset state and first cycle after release
    step("reset0", zero);
    step("reset1", zero);
    rst = 1'b0;
    step("post_reset", zero);

    // Load rd=5 in slot0, Decode slot1 rs2=5: exactly one stall cycle
    set_load_use();
    step("lu_hit", ev(ST_LU, FL_LU, 1'b0, S_RUN));
    idle();
    step("lu_release", zero);

    // Load to x0 never stalls
    mem_read_en_Issue = 2'b11; rs1_De[0] = 5'd0; rd_Issue = '0;
    step("lu_x0", zero);
    idle();

    // Random load-use patterns over a small register range for frequent hits
    for (int n = 0; n < 24; n++) begin
      for (int s = 0; s < 2; s++) begin
        rs1_De[s]   = 5'($urandom_range(0, 3));
        rs2_De[s]   = 5'($urandom_range(0, 3));
        rd_Issue[s] = 5'($urandom_range(0, 3));
      end
      mem_read_en_Issue = 2'($urandom_range(0, 3));
      step("lu_rand", ref_hazard(rs1_De, rs2_De, rd_Issue, mem_read_en_Issue)
                      ? ev(ST_LU, FL_LU, 1'b0, S_RUN) : zero);
    end
    idle();

    // Memory wait, ready on the 4th cycle; load-use ignored while waiting
    mem_req_Mem = 1'b1;
    step("mw_enter", ev(ST_ALL, FL_WB, 1'b0, S_RUN));
    set_load_use();
    step("mw_wait1_lu", ev(ST_ALL, FL_WB, 1'b0, S_MW));
    step("mw_wait2", ev(ST_ALL, FL_WB, 1'b0, S_MW));
    mem_read_en_Issue = '0;
    mem_ready_Mem = 1'b1;
    step("mw_exit", ev(ST_NONE, FL_NONE, 1'b0, S_MW));
    idle();
    step("mw_run", zero);

    // Taken branch, FLUSH_CYCLES=2, with a simultaneous load-use
    branch_taken_Ex = 1'b1; set_load_use();
    step("br_take", ev(ST_NONE, FL_BR, 1'b0, S_RUN));
    branch_taken_Ex = 1'b0;
    step("br_flush_lu", ev(ST_NONE, FL_DE, 1'b0, S_FL));
    idle();
    step("br_done", zero);

    // Back-to-back branch reloads the flush counter
    branch_taken_Ex = 1'b1;
    step("br2_take", ev(ST_NONE, FL_BR, 1'b0, S_RUN));
    step("br2_reload", ev(ST_NONE, FL_BR, 1'b0, S_FL));
    idle();
    step("br2_flush", ev(ST_NONE, FL_DE, 1'b0, S_FL));
    step("br2_done", zero);

    // Priority: memory wait over branch and load-use; branch held pending
    mem_req_Mem = 1'b1; branch_taken_Ex = 1'b1; set_load_use();
    step("pri_enter", ev(ST_ALL, FL_WB, 1'b0, S_RUN));
    step("pri_wait", ev(ST_ALL, FL_WB, 1'b0, S_MW));
    branch_taken_Ex = 1'b0; mem_read_en_Issue = '0; mem_ready_Mem = 1'b1;
    step("pri_exit_flush", ev(ST_NONE, FL_BR, 1'b0, S_MW));
    idle();
    step("pri_flush", ev(ST_NONE, FL_DE, 1'b0, S_FL));
    step("pri_done", zero);

    // Timeout: ready never comes
    mem_req_Mem = 1'b1;
    step("to_enter", ev(ST_ALL, FL_WB, 1'b0, S_RUN));
    for (int k = 0; k < 15; k++) step("to_wait", ev(ST_ALL, FL_WB, 1'b0, S_MW));
    step("to_exit", ev(ST_NONE, FL_NONE, 1'b0, S_MW));
    idle();
    for (int k = 0; k < 4; k++) step("to_sticky", ev(ST_NONE, FL_NONE, 1'b1, S_RUN));
    rst = 1'b1;
    step("to_rst", zero);
    rst = 1'b0;
    step("to_cleared", zero);

    // Branch during memory wait, then reset in the middle of FLUSH
    mem_req_Mem = 1'b1;
    step("mwbr_enter", ev(ST_ALL, FL_WB, 1'b0, S_RUN));
    branch_taken_Ex = 1'b1;
    step("mwbr_wait", ev(ST_ALL, FL_WB, 1'b0, S_MW));
    branch_taken_Ex = 1'b0; mem_ready_Mem = 1'b1;
    step("mwbr_exit", ev(ST_NONE, FL_BR, 1'b0, S_MW));
    idle(); rst = 1'b1;
    step("mwbr_rst_in_flush", zero);
    rst = 1'b0;
    step("mwbr_after_rst", zero);
    step("mwbr_idle", zero);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, the maximum number of memory-wait cycles before the error flag is raised.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, the number of cycles flush_De is held after a taken branch (range 1..4).
REQ-003 SHALL use one clock; reset is synchronous and active-high (clk, rst).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rs1_De, rs2_De  in  2x5  source registers of Decode slots 0/1.
REQ-007 rd_Issue  in  2x5  destination registers of Issue slots 0/1.
REQ-008 mem_read_en_Issue  in  2  load flag per Issue slot.
REQ-009 branch_taken_Ex  in  1  taken branch/jump redirect from the branch pipeline in Execute.
REQ-010 mem_req_Mem, mem_ready_Mem  in  1 each  data-memory access request and acknowledge in Mem.
REQ-011 stall_F, stall_De, stall_Issue, stall_Ex, stall_Mem  out  1 each  hold the PC or stage register.
REQ-012 flush_De, flush_Issue, flush_WB  out  1 each  load zeros (bubble) into the stage register.
REQ-013 mem_timeout  out  1  sticky error flag.
REQ-014 state_o  out  2  current FSM state, for debug.

Function
REQ-015 SHALL implement the FSM states RUN=0, MEM_WAIT=1, FLUSH=2.
REQ-016 Load-use hazard: for any Issue slot i with mem_read_en_Issue[i]=1 and rd_Issue[i]!=0 matching any rs1_De/rs2_De, SHALL detect a hazard.
REQ-017 A load-use hazard SHALL assert stall_F, stall_De and flush_Issue combinationally in the same cycle, with no state change.
REQ-018 Load-use hazards SHALL be ignored in FLUSH and MEM_WAIT.
REQ-019 RUN with mem_req_Mem=1 and mem_ready_Mem=0: SHALL assert all five stalls plus flush_WB in the same cycle, clear wait_cnt to 0, and go to MEM_WAIT.
REQ-020 MEM_WAIT while mem_ready_Mem=0: SHALL keep all five stalls and flush_WB asserted, and increment wait_cnt each cycle.
REQ-021 MEM_WAIT with mem_ready_Mem=1: SHALL deassert stalls and flush_WB in that cycle, and next state is FLUSH if a branch is pending, else RUN.
REQ-022 If wait_cnt reaches MEM_TIMEOUT, SHALL set mem_timeout (cleared only by rst) and leave MEM_WAIT as in REQ-021.
REQ-023 branch_taken_Ex in RUN with no memory wait: SHALL assert flush_De and flush_Issue that cycle with no stalls, load flush_cnt=FLUSH_CYCLES-1, and go to FLUSH if flush_cnt is nonzero.
REQ-024 branch_taken_Ex during MEM_WAIT: SHALL set a pending flag, and apply REQ-023 outputs in the cycle that MEM_WAIT exits.
REQ-025 FLUSH: SHALL assert flush_De only, decrement flush_cnt, and return to RUN when flush_cnt reaches 0.
REQ-026 A new branch_taken_Ex in FLUSH SHALL reload flush_cnt and assert flush_Issue.
REQ-027 Priority SHALL be memory wait > branch flush > load-use.
REQ-028 Simultaneous branch and load-use in RUN: SHALL produce flush only, with no stall.
REQ-029 Counter widths SHALL be $clog2(MEM_TIMEOUT+1) and 2 bits; counters SHALL NOT wrap.
REQ-030 Intra-bundle (slot0 to slot1) dependencies are out of scope for this block.

Reset
REQ-031 rst=1 at a clock edge SHALL set state=RUN, clear wait_cnt, flush_cnt, the pending flag and mem_timeout, and zero all outputs, including when reset is asserted mid-MEM_WAIT or mid-FLUSH.
REQ-032 All outputs SHALL be 0 during the cycle after reset is released, unless an input hazard is present.

Structure
REQ-033 Package pipeline_ctrl_pkg SHALL hold the state enum typedef and the default values of MEM_TIMEOUT and FLUSH_CYCLES; register-index widths SHALL come from the shared header constants RS/RD.
REQ-034 The load-use comparator SHALL be a sub-module, hazard_detect (purely combinational, 2x2x2 compares).

Verification
REQ-035 Test: Issue slot0 is a load with rd=5 and Decode slot1 has rs2=5 -> exactly one cycle of stall_F, stall_De and flush_Issue.
REQ-036 Test: load with rd=0 matching rs1=0 -> no stall.
REQ-037 Test: mem_req_Mem=1 with mem_ready_Mem=1 arriving on the 4th cycle -> all stalls high for 3 cycles, state 1 then 0.
REQ-038 Test: mem_ready_Mem never asserted -> mem_timeout=1 after 15 wait cycles; mem_timeout stays 1 until rst.
REQ-039 Test: branch_taken_Ex with FLUSH_CYCLES=2 -> flush_De high for 2 cycles and flush_Issue high for 1 cycle.
REQ-040 Test: branch during MEM_WAIT, then rst mid-FLUSH -> flush applied at MEM_WAIT exit; all outputs 0 and state 0 after the reset edge.
